// File: rtl/frame_buffer_tile_writer.sv
// rtl/frame_buffer_tile_writer.sv - maze tile / full-screen clear write sequencer for the 270x270 4-bit frame buffer
// Optional feature macro: FB_TILE_BORDER_EN (paint a 1-pixel grid line in BORDER_COLOR on each tile's top/left edge)

module frame_buffer_tile_writer_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;

  // Entry storage; occupancy is tracked by the pointers so the array needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

  // Read/write pointers carry an extra wrap bit to tell full from empty.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

module frame_buffer_tile_writer #(
  parameter int         GRID_DIM     = 9,
  parameter int         TILE_PX      = 30,
  parameter int         SCREEN_WIDTH = 270,
  parameter int         ADDR_W       = 17,
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [3:0] BORDER_COLOR = 4'h0
) (
  input  logic              clk_W,
  input  logic              reset_n,
  input  logic              cell_valid,
  output logic              cell_ready,
  input  logic [3:0]        cell_x,
  input  logic [3:0]        cell_y,
  input  logic [3:0]        cell_color,
  input  logic              clear_req,
  input  logic [3:0]        clear_color,
  output logic              busy,
  output logic              err_oob,
  output logic [ADDR_W-1:0] w_addr,
  output logic              w_en,
  output logic [3:0]        input_data
);

  localparam int PW = $clog2(TILE_PX);
  localparam logic [PW-1:0]     PX_LAST     = PW'(TILE_PX - 1);
  localparam logic [PW-1:0]     PX_ONE      = PW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(SCREEN_WIDTH * SCREEN_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP    = ADDR_W'(SCREEN_WIDTH - TILE_PX + 1);
  localparam logic [ADDR_W-1:0] CELL_ROW_SZ = ADDR_W'(TILE_PX * SCREEN_WIDTH);
  localparam logic [ADDR_W-1:0] CELL_COL_SZ = ADDR_W'(TILE_PX);
  localparam logic [3:0]        GRID_LIM    = 4'(GRID_DIM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_TILE
  } state_e;

  state_e            state_q, state_d;
  logic              w_en_q, w_en_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [3:0]        data_q, data_d;
  logic [3:0]        col_q, col_d;
  logic [PW-1:0]     px_q, px_d;
  logic [PW-1:0]     py_q, py_d;
  logic              clr_pend_q, clr_pend_d;
  logic [3:0]        clr_col_q, clr_col_d;
  logic              err_oob_q, err_oob_d;

  logic              req_oob;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [11:0]       fifo_rdata;
  logic [3:0]        q_x;
  logic [3:0]        q_y;
  logic [3:0]        q_color;
  logic              clr_take;
  logic [ADDR_W-1:0] tile_base;
  logic [3:0]        entry_data;
  logic [3:0]        row_start_data;
  logic [3:0]        in_row_data;

  assign req_oob   = (cell_x >= GRID_LIM) || (cell_y >= GRID_LIM);
  assign fifo_push = cell_valid && cell_ready && !req_oob;

  frame_buffer_tile_writer_fifo #(
    .W     (12),
    .DEPTH (FIFO_DEPTH)
  ) u_cell_fifo (
    .clk_i   (clk_W),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .data_i  ({cell_x, cell_y, cell_color}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign q_x     = fifo_rdata[11:8];
  assign q_y     = fifo_rdata[7:4];
  assign q_color = fifo_rdata[3:0];

  // Top-left pixel of the cell; one multiply per tile, pixels then step incrementally.
  assign tile_base = ADDR_W'(q_y) * CELL_ROW_SZ + ADDR_W'(q_x) * CELL_COL_SZ;

  // Colour for the tile's first pixel, the first pixel of each new row, and the next pixel in the current row.
  always_comb begin
`ifdef FB_TILE_BORDER_EN
    entry_data     = BORDER_COLOR;
    row_start_data = BORDER_COLOR;
    in_row_data    = (py_q == '0) ? BORDER_COLOR : col_q;
`else
    entry_data     = q_color;
    row_start_data = col_q;
    in_row_data    = col_q;
`endif
  end

`ifndef FB_TILE_BORDER_EN
  logic unused_border;
  assign unused_border = ^BORDER_COLOR;
`endif

  // Sequencer: picks the next operation in IDLE and walks the pixel addresses of a clear or tile.
  always_comb begin
    state_d  = state_q;
    w_en_d   = w_en_q;
    w_addr_d = w_addr_q;
    data_d   = data_q;
    col_d    = col_q;
    px_d     = px_q;
    py_d     = py_q;
    fifo_pop = 1'b0;
    clr_take = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_en_d = 1'b0;
        if (clr_pend_q) begin
          clr_take = 1'b1;
          state_d  = ST_CLEAR;
          w_en_d   = 1'b1;
          w_addr_d = '0;
          col_d    = clr_col_q;
          data_d   = clr_col_q;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ST_TILE;
          w_en_d   = 1'b1;
          w_addr_d = tile_base;
          col_d    = q_color;
          data_d   = entry_data;
          px_d     = '0;
          py_d     = '0;
        end
      end
      ST_CLEAR: begin
        if (w_addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          w_en_d  = 1'b0;
        end else begin
          w_addr_d = w_addr_q + ADDR_ONE;
        end
      end
      ST_TILE: begin
        if (px_q == PX_LAST) begin
          if (py_q == PX_LAST) begin
            state_d = ST_IDLE;
            w_en_d  = 1'b0;
          end else begin
            px_d     = '0;
            py_d     = py_q + PX_ONE;
            w_addr_d = w_addr_q + ROW_STEP;
            data_d   = row_start_data;
          end
        end else begin
          px_d     = px_q + PX_ONE;
          w_addr_d = w_addr_q + ADDR_ONE;
          data_d   = in_row_data;
        end
      end
      default: begin
        state_d = ST_IDLE;
        w_en_d  = 1'b0;
      end
    endcase
  end

  // Clear requests are sticky until IDLE takes them; a newer request replaces the colour.
  always_comb begin
    clr_pend_d = clear_req | (clr_pend_q & ~clr_take);
    clr_col_d  = clear_req ? clear_color : clr_col_q;
    err_oob_d  = cell_valid && cell_ready && req_oob;
  end

  // State and output registers; reset aborts any operation in progress at once.
  always_ff @(posedge clk_W or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      data_q     <= '0;
      col_q      <= '0;
      px_q       <= '0;
      py_q       <= '0;
      clr_pend_q <= 1'b0;
      clr_col_q  <= '0;
      err_oob_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      data_q     <= data_d;
      col_q      <= col_d;
      px_q       <= px_d;
      py_q       <= py_d;
      clr_pend_q <= clr_pend_d;
      clr_col_q  <= clr_col_d;
      err_oob_q  <= err_oob_d;
    end
  end

  assign cell_ready = !fifo_full;
  assign busy       = (state_q != ST_IDLE) || !fifo_empty || clr_pend_q;
  assign err_oob    = err_oob_q;
  assign w_en       = w_en_q;
  assign w_addr     = w_addr_q;
  assign input_data = data_q;

endmodule

// File: tb/tb_frame_buffer_tile_writer.sv
// tb/tb_frame_buffer_tile_writer.sv - scoreboard bench for frame_buffer_tile_writer
module tb_frame_buffer_tile_writer;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [3:0] c;
  } cell_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cell_valid;
  logic        cell_ready;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic [3:0]  cell_color;
  logic        clear_req;
  logic [3:0]  clear_color;
  logic        busy;
  logic        err_oob;
  logic [16:0] w_addr;
  logic        w_en;
  logic [3:0]  input_data;

  int total = 0;
  int bad = 0;

  cell_t exp_cells[$];
  logic  exp_clear_pend = 1'b0;
  int    exp_clear_col = 0;
  int    ops_done = 0;

  always #5 clk = ~clk;

  frame_buffer_tile_writer dut (
    .clk_W       (clk),
    .reset_n     (reset_n),
    .cell_valid  (cell_valid),
    .cell_ready  (cell_ready),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .cell_color  (cell_color),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .busy        (busy),
    .err_oob     (err_oob),
    .w_addr      (w_addr),
    .w_en        (w_en),
    .input_data  (input_data)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Monitor: each write burst is one operation; the next one to start is the pending clear if any, else the oldest cell.
  logic  in_op = 1'b0;
  logic  op_clear, op_stray;
  int    op_x, op_y, op_col, op_n, op_k, op_bad, op_idx = 0;
  int    fb_k, fb_addr, fb_data, fb_eaddr, fb_edata;

  always @(negedge clk) begin : monitor
    int    ea, ed, px, py;
    cell_t c;
    if (!reset_n) begin
      in_op = 1'b0;
    end else if (w_en) begin
      if (!in_op) begin
        in_op  = 1'b1;
        op_k   = 0;
        op_bad = 0;
        op_stray = 1'b0;
        op_idx++;
        if (exp_clear_pend) begin
          exp_clear_pend = 1'b0;
          op_clear = 1'b1;
          op_col   = exp_clear_col;
          op_n     = 270 * 270;
        end else if (exp_cells.size() > 0) begin
          c = exp_cells.pop_front();
          op_clear = 1'b0;
          op_x   = int'(c.x);
          op_y   = int'(c.y);
          op_col = int'(c.c);
          op_n   = 30 * 30;
        end else begin
          op_stray = 1'b1;
          op_n = 0;
        end
      end
      if (op_clear) begin
        ea = op_k;
        ed = op_col;
      end else begin
        px = op_k % 30;
        py = op_k / 30;
        ea = op_y * 30 * 270 + op_x * 30 + py * 270 + px;
        ed = op_col;
`ifdef FB_TILE_BORDER_EN
        if (px == 0 || py == 0) ed = 0;
`endif
      end
      if (op_k >= op_n || int'(w_addr) != ea || int'(input_data) != ed || int'(w_addr) > 72899) begin
        if (op_bad == 0) begin
          fb_k = op_k; fb_addr = int'(w_addr); fb_data = int'(input_data);
          fb_eaddr = ea; fb_edata = ed;
        end
        op_bad++;
      end
      op_k++;
    end else if (in_op) begin
      in_op = 1'b0;
      if (op_stray) begin
        check($sformatf("op%0d_stray_writes", op_idx), op_k, 0);
      end else begin
        check($sformatf("op%0d_len", op_idx), op_k, op_n);
        check($sformatf("op%0d_pixels", op_idx), op_bad, 0);
        if (op_bad != 0)
          $display("  op%0d first bad idx=%0d addr=%0d data=%0d, expected addr=%0d data=%0d",
                   op_idx, fb_k, fb_addr, fb_data, fb_eaddr, fb_edata);
        ops_done++;
      end
    end
  end

  task automatic push(input int x, input int y, input int c);
    int n = 0;
    @(negedge clk);
    cell_valid = 1'b1;
    cell_x = 4'(x);
    cell_y = 4'(y);
    cell_color = 4'(c);
    while (!cell_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!cell_ready) check("push_ready_timeout", cell_ready, 1);
    @(posedge clk);
    if (x < 9 && y < 9) exp_cells.push_back(cell_t'({4'(x), 4'(y), 4'(c)}));
  endtask

  task automatic release_valid();
    @(negedge clk);
    cell_valid = 1'b0;
  endtask

  task automatic clear_pulse(input int c);
    @(negedge clk);
    clear_req = 1'b1;
    clear_color = 4'(c);
    @(posedge clk);
    exp_clear_pend = 1'b1;
    exp_clear_col = c;
    @(negedge clk);
    clear_req = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    @(negedge clk); #1;
    while ((busy || w_en) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    check({"idle_", name}, busy, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    cell_valid = 1'b0;
    cell_x = '0; cell_y = '0; cell_color = '0;
    clear_req = 1'b0;
    clear_color = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_w_en", w_en, 0);
    check("rst_w_addr", w_addr, 0);
    check("rst_input_data", input_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_oob", err_oob, 0);
    check("rst_cell_ready", cell_ready, 1);
    @(negedge clk);
    reset_n = 1'b1;

    // Corner cell (0,0): first write lands the cycle after the IDLE decision.
    push(0, 0, 5);
    release_valid();
    #1 check("lat_decision_w_en", w_en, 0);
    @(negedge clk); #1;
    check("lat_first_w_en", w_en, 1);
    check("lat_first_w_addr", w_addr, 0);
    wait_idle("t1", 2000);

    // Far corner cell (8,8): last address is the last pixel of the screen.
    push(8, 8, 10);
    release_valid();
    wait_idle("t2", 2000);

    // Five back-to-back requests: queue fills after the first is popped.
    for (int i = 0; i < 5; i++)
      push($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 15));
    release_valid();
    #1 check("t3_ready_when_full", cell_ready, (exp_cells.size() < 4) ? 1 : 0);
    wait_idle("t3", 8000);

    // Clear arrives mid-tile with two cells queued behind it.
    for (int i = 0; i < 3; i++)
      push($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 15));
    release_valid();
    repeat (50) @(negedge clk);
    clear_pulse(3);
    wait_idle("t4", 80000);

    // Out-of-range requests: accepted, pulse err_oob, never written.
    for (int i = 0; i < 3; i++) begin
      if (i == 0) push(9, 2, 7);
      else if (i == 1) push($urandom_range(0, 8), $urandom_range(9, 15), 1);
      else push($urandom_range(9, 15), $urandom_range(0, 15), 2);
      release_valid();
      #1;
      check($sformatf("t5_err_oob_pulse%0d", i), err_oob, 1);
      check($sformatf("t5_busy%0d", i), busy, (in_op || exp_cells.size() > 0 || exp_clear_pend) ? 1 : 0);
      @(negedge clk); #1;
      check($sformatf("t5_err_oob_clear%0d", i), err_oob, 0);
    end
    repeat (5) @(negedge clk);

    // Reset in the middle of a clear with cells queued.
    clear_pulse($urandom_range(0, 15));
    repeat (100) @(negedge clk);
    push($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 15));
    push($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 15));
    release_valid();
    repeat (100) @(negedge clk);
    #2 reset_n = 1'b0;
    exp_cells.delete();
    exp_clear_pend = 1'b0;
    #1;
    check("t6_async_w_en", w_en, 0);
    check("t6_async_busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("t6_busy_after", busy, 0);
    check("t6_ready_after", cell_ready, 1);
    repeat (20) @(negedge clk);

    // One more tile to show the block recovers after reset.
    push($urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 15));
    release_valid();
    wait_idle("final", 2000);
    check("drain_queue", exp_cells.size(), 0);
    check("ops_completed", ops_done, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
